// File: rtl/fc_head_pkg.sv
// Shared constants, types and the per-element MAC term for the FC classification head.
package fc_head_pkg;
  localparam int NUM_ELEMS   = 64;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 8;
  localparam int W_W         = 8;
  localparam int NUM_CLASSES = 10;
  localparam int CLS_W       = 4;
  localparam int ACC_W       = 24;
  localparam int PROD_W      = DATA_W + W_W + 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [W_W-1:0]   weight_t;

  typedef enum logic [1:0] {COLLECT, SEED, SCAN, EMIT} fc_state_t;

  // Feature data is unsigned: widen with a zero MSB before the signed multiply.
  function automatic acc_t mac_term(input logic [DATA_W-1:0] d, input weight_t w);
    logic signed [DATA_W:0]   w_d;
    logic signed [PROD_W-1:0] w_p;
    w_d = $signed({1'b0, d});
    w_p = PROD_W'(w_d) * PROD_W'(w);
    return acc_t'(w_p);
  endfunction
endpackage

// File: rtl/fc_class_head_if.sv
// Feature-element input stream and class-decision output bundle of fc_class_head.
interface fc_class_head_if;
  import fc_head_pkg::*;

  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [CLS_W-1:0]  cls_id;
  acc_t              cls_score;
  logic              cls_valid;
  logic              err_dup;
  logic              err_drop;

  modport master (
    output in_addr, in_data, in_valid,
    input  cls_id, cls_score, cls_valid, err_dup, err_drop
  );

  modport slave (
    input  in_addr, in_data, in_valid,
    output cls_id, cls_score, cls_valid, err_dup, err_drop
  );
endinterface

// File: rtl/fc_mac_lane.sv
// One class lane: constant weight ROM slice selected by CLASS_IDX plus a signed accumulator.
module fc_mac_lane
  import fc_head_pkg::*;
#(
  parameter int CLASS_IDX = 0,
  parameter logic [NUM_CLASSES*NUM_ELEMS*W_W-1:0] WEIGHTS = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  acc_t              i_init,
  input  logic              i_load,
  input  logic              i_acc_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output acc_t              o_acc
);
  weight_t w_rom [NUM_ELEMS];
  weight_t w_wgt;
  acc_t    r_acc;

  // Class-major layout: entry index = class*NUM_ELEMS + addr.
  for (genvar a = 0; a < NUM_ELEMS; a++) begin : g_rom
    assign w_rom[a] = weight_t'(WEIGHTS[(CLASS_IDX*NUM_ELEMS+a)*W_W +: W_W]);
  end

  assign w_wgt = w_rom[i_addr];

  always_ff @(posedge clk) begin
    if (reset || i_load)
      r_acc <= i_init;
    else if (i_acc_en)
      r_acc <= r_acc + mac_term(i_data, w_wgt);
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/fc_class_head.sv
// FC classification head: collects a 64-element frame, MACs into per-class lanes, argmax, emit.
// Optional FC_BIAS_EN: accumulators restart from (bias << DATA_W) instead of zero.
module fc_class_head
  import fc_head_pkg::*;
#(
  parameter logic [NUM_CLASSES*NUM_ELEMS*W_W-1:0] WEIGHT_INIT = '0
`ifdef FC_BIAS_EN
  , parameter logic [NUM_CLASSES*W_W-1:0] BIAS_INIT = '0
`endif
) (
  input  logic clk,
  input  logic reset,
  fc_class_head_if.slave bus
);
  fc_state_t            r_state, w_state_nxt;
  logic [NUM_ELEMS-1:0] r_mask, w_mask_nxt;
  logic [CLS_W-1:0]     r_idx, r_best_idx, r_cls_id;
  acc_t                 r_best, r_cls_score;
  logic                 r_cls_valid, r_err_dup, r_err_drop;
  logic                 w_collect, w_new, w_dup, w_drop;
  logic                 w_seed, w_scan, w_emit;
  acc_t                 w_acc  [NUM_CLASSES];
  acc_t                 w_init [NUM_CLASSES];

  assign w_collect = (r_state == COLLECT);
  assign w_new     = bus.in_valid && w_collect && !r_mask[bus.in_addr];
  assign w_dup     = bus.in_valid && w_collect &&  r_mask[bus.in_addr];
  assign w_drop    = bus.in_valid && !w_collect;

  always_comb begin
    w_mask_nxt = r_mask;
    if (w_new) w_mask_nxt[bus.in_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seed      = 1'b0;
    w_scan      = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      COLLECT: if (w_new && (&w_mask_nxt)) w_state_nxt = SEED;
      SEED: begin
        w_seed      = 1'b1;
        w_state_nxt = SCAN;
      end
      SCAN: begin
        w_scan = 1'b1;
        if (r_idx == CLS_W'(NUM_CLASSES-1)) w_state_nxt = EMIT;
      end
      EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask      <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best      <= '0;
      r_cls_id    <= '0;
      r_cls_score <= '0;
      r_cls_valid <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_drop  <= 1'b0;
    end else begin
      r_mask      <= w_emit ? '0 : w_mask_nxt;
      r_cls_valid <= w_emit;
      r_err_dup   <= r_err_dup  | w_dup;
      r_err_drop  <= r_err_drop | w_drop;
      if (w_seed) begin
        r_best     <= w_acc[0];
        r_best_idx <= '0;
        r_idx      <= CLS_W'(1);
      end
      // Strict compare keeps the lowest index on ties.
      if (w_scan) begin
        if (w_acc[r_idx] > r_best) begin
          r_best     <= w_acc[r_idx];
          r_best_idx <= r_idx;
        end
        r_idx <= r_idx + CLS_W'(1);
      end
      if (w_emit) begin
        r_cls_id    <= r_best_idx;
        r_cls_score <= r_best;
      end
    end
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
`ifdef FC_BIAS_EN
    assign w_init[c] = acc_t'(weight_t'(BIAS_INIT[c*W_W +: W_W])) <<< DATA_W;
`else
    assign w_init[c] = '0;
`endif
    fc_mac_lane #(
      .CLASS_IDX (c),
      .WEIGHTS   (WEIGHT_INIT)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_init   (w_init[c]),
      .i_load   (w_emit),
      .i_acc_en (w_new),
      .i_addr   (bus.in_addr),
      .i_data   (bus.in_data),
      .o_acc    (w_acc[c])
    );
  end

  assign bus.cls_id    = r_cls_id;
  assign bus.cls_score = r_cls_score;
  assign bus.cls_valid = r_cls_valid;
  assign bus.err_dup   = r_err_dup;
  assign bus.err_drop  = r_err_drop;
endmodule

// File: tb/tb_fc_class_head.sv
// Bench for fc_class_head: five weight sets driven in lockstep, scored by a sum-of-products model.
module tb_fc_class_head;
  import fc_head_pkg::*;

  localparam int NDUT = 5;
`ifdef FC_BIAS_EN
  localparam longint BIAS_ON = 1;
`else
  localparam longint BIAS_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_vld = 1'b0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] s_data = '0;
  logic [NDUT-1:0]   t_vld, t_dup, t_drop;
  logic [CLS_W-1:0]  t_id    [NDUT];
  acc_t              t_score [NDUT];
  int                n_vec = 0;
  int                n_err = 0;
  int                fd [NUM_ELEMS];

  always #5 clk = ~clk;

  function automatic int wt(input int k, input int c, input int a);
    case (k)
      0:       return ((c*53 + a*29 + c*a*7 + 13) % 256) - 128;
      1:       return 1;
      2:       return (c == 3) ? 2 : 1;
      3:       return (c == 0) ? -128 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int bs(input int k, input int c);
    if (k == 0) return (c % 5) - 2;
    if (k >= 3) return (c == 2) ? 1 : 0;
    return 0;
  endfunction

  function automatic logic [NUM_CLASSES*NUM_ELEMS*W_W-1:0] mk_w(input int k);
    logic [NUM_CLASSES*NUM_ELEMS*W_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CLASSES; c++)
      for (int a = 0; a < NUM_ELEMS; a++)
        r[(c*NUM_ELEMS+a)*W_W +: W_W] = W_W'(wt(k, c, a));
    return r;
  endfunction

  function automatic logic [NUM_CLASSES*W_W-1:0] mk_b(input int k);
    logic [NUM_CLASSES*W_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CLASSES; c++) r[c*W_W +: W_W] = W_W'(bs(k, c));
    return r;
  endfunction

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    fc_class_head_if u_if ();
    assign u_if.in_valid = s_vld;
    assign u_if.in_addr  = s_addr;
    assign u_if.in_data  = s_data;
    assign t_vld[k]   = u_if.cls_valid;
    assign t_dup[k]   = u_if.err_dup;
    assign t_drop[k]  = u_if.err_drop;
    assign t_id[k]    = u_if.cls_id;
    assign t_score[k] = u_if.cls_score;

    fc_class_head #(
      .WEIGHT_INIT (mk_w(k))
`ifdef FC_BIAS_EN
      , .BIAS_INIT (mk_b(k))
`endif
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int a, input int d);
    s_vld  = 1'b1;
    s_addr = ADDR_W'(a);
    s_data = DATA_W'(d);
    @(negedge clk);
    s_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (t_vld != '0) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Score = bias*2^DATA_W + sum(data*weight); winner = first index holding the maximum.
  task automatic check_result(input string tag);
    longint s, best;
    int     bi;
    for (int k = 0; k < NDUT; k++) begin
      best = 0;
      bi   = 0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        s = BIAS_ON * longint'(bs(k, c)) * 256;
        for (int a = 0; a < NUM_ELEMS; a++) s += longint'(fd[a]) * longint'(wt(k, c, a));
        if (c == 0 || s > best) begin
          best = s;
          bi   = c;
        end
      end
      check($sformatf("%s_id%0d", tag, k), t_id[k], bi);
      check($sformatf("%s_score%0d", tag, k), t_score[k], best);
    end
  endtask

  // Called on the negedge right after the last element's sampling edge.
  task automatic wait_result(input string tag, input int drop_at);
    int lat, pulses;
    logic [NDUT-1:0] v_at;
    lat    = -1;
    pulses = 0;
    v_at   = '0;
    for (int n = 1; n <= 14; n++) begin
      if (n == drop_at) begin
        s_vld  = 1'b1;
        s_addr = '0;
        s_data = '1;
      end
      @(negedge clk);
      s_vld = 1'b0;
      if (t_vld != '0) begin
        pulses++;
        if (lat < 0) begin
          lat  = n;
          v_at = t_vld;
        end
      end
    end
    check({tag, "_lat"}, lat, NUM_CLASSES + 1);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_vall"}, v_at, {NDUT{1'b1}});
    check_result(tag);
  endtask

  // mode 0: random data/order/gaps, 1: ramp in order, 2: all 255 random order.
  task automatic do_frame(input string tag, input int mode, input int drop_at);
    int ord [NUM_ELEMS];
    int j, tmp, a, d;
    for (int i = 0; i < NUM_ELEMS; i++) ord[i] = i;
    if (mode != 1)
      for (int i = NUM_ELEMS-1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    for (int i = 0; i < NUM_ELEMS; i++) begin
      a = ord[i];
      d = (mode == 1) ? a : (mode == 2) ? 255 : int'($urandom_range(0, 255));
      fd[a] = d;
      send(a, d);
      if (mode == 0 && i != NUM_ELEMS-1 && $urandom_range(0, 3) == 0)
        idle(int'($urandom_range(1, 3)));
    end
    if (drop_at >= 0) wait_result(tag, drop_at);
  endtask

  initial begin
    int d;
    idle(2);
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_id%0d", k), t_id[k], 0);
      check($sformatf("rst_score%0d", k), t_score[k], 0);
    end
    check("rst_vld", t_vld, 0);
    check("rst_dup", t_dup, 0);
    check("rst_drop", t_drop, 0);

    do_frame("ramp", 1, 0);
    do_frame("sat", 2, 0);
    for (int i = 0; i < 6; i++) do_frame($sformatf("rnd%0d", i), 0, 0);
    check("clean_dup", t_dup, 0);
    check("clean_drop", t_drop, 0);

    // Frame missing addr 17 with addr 5 repeated: no decision until 17 arrives.
    for (int a = 0; a < NUM_ELEMS; a++)
      if (a != 17) begin
        fd[a] = int'($urandom_range(0, 255));
        send(a, fd[a]);
      end
    send(5, fd[5] ^ 8'hA5);
    watch_quiet("dup_quiet", 15);
    check("dup_flag", t_dup, {NDUT{1'b1}});
    fd[17] = int'($urandom_range(0, 255));
    send(17, fd[17]);
    wait_result("dup", 0);

    do_frame("drop", 0, 4);
    check("drop_flag", t_drop, {NDUT{1'b1}});
    do_frame("post_drop", 0, 0);
    check("dup_sticky", t_dup, {NDUT{1'b1}});

    // Reset three cycles into SCAN aborts the decision and clears everything.
    do_frame("abort", 0, -1);
    idle(3);
    reset = 1'b1;
    watch_quiet("rst_scan_quiet", 2);
    reset = 1'b0;
    watch_quiet("post_rst_quiet", 13);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst2_id%0d", k), t_id[k], 0);
      check($sformatf("rst2_score%0d", k), t_score[k], 0);
    end
    check("rst2_dup", t_dup, 0);
    check("rst2_drop", t_drop, 0);
    do_frame("fresh", 0, 0);
    do_frame("ramp2", 1, 0);

    d = n_err;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, d);
    $finish;
  end
endmodule
